// File: rtl/mips_lite_non_pipeline.sv
// rtl/mips_lite_non_pipeline.sv - multi-cycle MIPS-lite reference core (optional MIPS_MUL_EN enables MUL/MULI)
module mips_lite_non_pipeline #(
  parameter int FUN = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        fex,
  output logic [31:0] pc_out,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count,
  output logic [31:0] branch_count
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED
  } state_t;

  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic        taken_q, taken_d;
  logic [31:0] icnt_q, icnt_d, ccnt_q, ccnt_d, bcnt_q, bcnt_d;
  logic [31:0] regs_q [32];

  logic [5:0]  op;
  logic [4:0]  rt, rd;
  logic [31:0] imm_sext, op_b, alu_res;
  logic        branch_taken, op_legal, writes_reg;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op       = ir_q[31:26];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign op_b     = op[0] ? imm_sext : b_q;

`ifdef MIPS_MUL_EN
  assign op_legal = (op <= OP_HALT);
`else
  logic is_mul_op;
  assign is_mul_op = (op == 6'h04) || (op == 6'h05);
  assign op_legal  = (op <= OP_HALT) && !is_mul_op;
`endif

  // Only legal ALU ops and LDW write the register file; even ALU opcodes target rd.
  assign writes_reg = op_legal && (op <= OP_LDW);
  assign rf_waddr   = ((op <= 6'h0B) && !op[0]) ? rd : rt;
  assign rf_wdata   = (op == OP_LDW) ? mem_rdata : alu_q;

  // ALU, effective address and branch resolution; branch targets go into alu_q.
  always_comb begin
    alu_res      = 32'd0;
    branch_taken = 1'b0;
    case (op)
      6'h00, 6'h01: alu_res = a_q + op_b;
      6'h02, 6'h03: alu_res = a_q - op_b;
`ifdef MIPS_MUL_EN
      6'h04, 6'h05: alu_res = a_q * op_b;
`endif
      6'h06, 6'h07: alu_res = a_q | op_b;
      6'h08, 6'h09: alu_res = a_q & op_b;
      6'h0A, 6'h0B: alu_res = a_q ^ op_b;
      OP_LDW, OP_STW: alu_res = a_q + imm_sext;
      OP_BZ: begin
        alu_res      = pc_q + {imm_sext[29:0], 2'b00};
        branch_taken = (a_q == 32'd0);
      end
      OP_BEQ: begin
        alu_res      = pc_q + {imm_sext[29:0], 2'b00};
        branch_taken = (a_q == b_q);
      end
      OP_JR: begin
        alu_res      = {a_q[31:2], 2'b00};
        branch_taken = 1'b1;
      end
      default: alu_res = 32'd0;
    endcase
  end

  // Next-state logic for the five-step instruction sequence and the counters.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    taken_d = taken_q;
    icnt_d  = icnt_q;
    ccnt_d  = ccnt_q;
    bcnt_d  = bcnt_q;
    rf_we   = 1'b0;
    if (state_q != S_HALTED) ccnt_d = ccnt_q + 32'd1;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = mem_rdata;
        a_d     = regs_q[mem_rdata[25:21]];
        b_d     = regs_q[mem_rdata[20:16]];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_d   = alu_res;
        taken_d = branch_taken;
        state_d = S_MEMORY;
      end
      S_MEMORY:  state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        rf_we  = writes_reg;
        icnt_d = icnt_q + {31'd0, op_legal};
        bcnt_d = bcnt_q + {31'd0, taken_q};
        if (op == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          pc_d    = taken_q ? alu_q : pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_FETCH;
    endcase
  end

  // Architectural and sequencing state; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 32'd0;
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_q   <= 32'd0;
      taken_q <= 1'b0;
      icnt_q  <= 32'd0;
      ccnt_q  <= 32'd0;
      bcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      taken_q <= taken_d;
      icnt_q  <= icnt_d;
      ccnt_q  <= ccnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Register file; R0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Memory port decode; strobes are held low while reset is asserted.
  always_comb begin
    mem_addr  = 32'd0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    if (!rst) begin
      if (state_q == S_FETCH) begin
        mem_addr = pc_q;
        mem_re   = 1'b1;
      end else if (state_q == S_MEMORY && op == OP_LDW) begin
        mem_addr = {alu_q[31:2], 2'b00};
        mem_re   = 1'b1;
      end else if (state_q == S_MEMORY && op == OP_STW) begin
        mem_addr  = {alu_q[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = b_q;
      end
    end
  end

  assign fex          = (state_q == S_HALTED);
  assign pc_out       = pc_q;
  assign instr_count  = (FUN != 0) ? icnt_q : 32'd0;
  assign cycle_count  = (FUN != 0) ? ccnt_q : 32'd0;
  assign branch_count = (FUN != 0) ? bcnt_q : 32'd0;

endmodule

// File: tb/tb_mips_lite_non_pipeline.sv
// tb/tb_mips_lite_non_pipeline.sv - directed program vectors for mips_lite_non_pipeline
module tb_mips_lite_non_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr, mem_rdata, mem_wdata, pc_out;
  logic        mem_re, mem_we, fex;
  logic [31:0] instr_count, cycle_count, branch_count;

  mips_lite_non_pipeline #(.FUN(1)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .fex(fex), .pc_out(pc_out),
    .instr_count(instr_count), .cycle_count(cycle_count), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  // Word memory; preload and DUT traffic both go through this one process.
  logic [31:0] mem [0:1023];
  logic        ld_we = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic [31:0] ld_data = 32'd0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  initial mem_rdata = 32'd0;
  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] = ld_data;
    if (mem_re && mem_we) both_cnt++;
    if (mem_we) begin
      mem[mem_addr[11:2]] = mem_wdata;
      wr_cnt++;
    end
    if (mem_re) mem_rdata <= mem[mem_addr[11:2]];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fi(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] fr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  localparam logic [31:0] HALT = 32'h4400_0000;

  typedef struct {
    string       name;
    int          r;
    logic [31:0] rv;
    int          ic, cc, bc, wr;
    bit          cm;
    logic [31:0] ma, mv;
  } vec_t;

  vec_t        vecs [10];
  int          pv_id [$];
  logic [31:0] pv_a [$];
  logic [31:0] pv_w [$];

  task automatic pl(input int id, input logic [31:0] a, input logic [31:0] w);
    pv_id.push_back(id);
    pv_a.push_back(a);
    pv_w.push_back(w);
  endtask

  function automatic vec_t mk(input string nm, input int r, input logic [31:0] rv, input int ic,
                              input int cc, input int bc, input int wr, input bit cm,
                              input logic [31:0] ma, input logic [31:0] mv);
    vec_t v;
    v.name = nm; v.r = r; v.rv = rv; v.ic = ic; v.cc = cc; v.bc = bc; v.wr = wr;
    v.cm = cm; v.ma = ma; v.mv = mv;
    return v;
  endfunction

  task automatic put(input int a, input logic [31:0] d);
    ld_we = 1'b1;
    ld_addr = a[9:0];
    ld_data = d;
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  // Holds reset, clears low memory and places program vid; returns with rst still high.
  task automatic load_vec(input int vid);
    rst = 1'b1;
    for (int i = 0; i < 80; i++) put(i, 32'd0);
    for (int i = 0; i < pv_id.size(); i++)
      if (pv_id[i] == vid) put(int'(pv_a[i] >> 2), pv_w[i]);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int k);
    int n, w0;
    load_vec(k);
    w0 = wr_cnt;
    release_rst();
    n = 0;
    while (!fex && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({vecs[k].name, " fex_latency"}, n, vecs[k].cc);
    chk({vecs[k].name, " fex"}, {31'd0, fex}, 32'd1);
    chk({vecs[k].name, " reg"}, dut.regs_q[vecs[k].r], vecs[k].rv);
    chk({vecs[k].name, " instr_count"}, instr_count, vecs[k].ic);
    chk({vecs[k].name, " cycle_count"}, cycle_count, vecs[k].cc);
    chk({vecs[k].name, " branch_count"}, branch_count, vecs[k].bc);
    chk({vecs[k].name, " stores"}, wr_cnt - w0, vecs[k].wr);
    if (vecs[k].cm) chk({vecs[k].name, " mem"}, mem[vecs[k].ma[11:2]], vecs[k].mv);
    repeat (3) @(negedge clk);
    chk({vecs[k].name, " halted_frozen"}, {cycle_count[30:0], mem_re | mem_we}, {vecs[k].cc[30:0], 1'b0});
  endtask

  task automatic check_fetch(input string nm, input int vid, input int cyc, input logic [31:0] a);
    load_vec(vid);
    release_rst();
    repeat (cyc - 1) @(negedge clk);
    #1;
    chk({nm, " mem_re"}, {31'd0, mem_re}, 32'd1);
    chk({nm, " mem_addr"}, mem_addr, a);
    chk({nm, " pc_out"}, pc_out, a);
  endtask

  initial begin
    int n, w0;
    logic [31:0] r6_exp, r8_exp;
    int mul_ic, muli_ic;
`ifdef MIPS_MUL_EN
    r6_exp = 32'd0; mul_ic = 6; r8_exp = 32'hFFFF_FFEB; muli_ic = 3;
`else
    r6_exp = 32'd9; mul_ic = 5; r8_exp = 32'd0; muli_ic = 2;
`endif
    // 0: basic add
    pl(0, 'h00, fi(6'h01, 0, 1, 5)); pl(0, 'h04, fi(6'h01, 0, 2, -3));
    pl(0, 'h08, fr(6'h00, 3, 1, 2)); pl(0, 'h0C, HALT);
    vecs[0] = mk("add", 3, 32'd2, 4, 20, 0, 0, 0, 0, 0);
    // 1: logic chain
    pl(1, 'h00, fi(6'h01, 0, 1, 'h0F0F)); pl(1, 'h04, fi(6'h0B, 1, 2, 'h00FF));
    pl(1, 'h08, fi(6'h09, 2, 3, 'h0F00)); pl(1, 'h0C, fi(6'h07, 3, 4, -16));
    pl(1, 'h10, fr(6'h02, 5, 4, 2)); pl(1, 'h14, HALT);
    vecs[1] = mk("logic", 5, 32'hFFFF_F000, 6, 30, 0, 0, 0, 0, 0);
    // 2: MUL wrap
    pl(2, 'h00, fi(6'h01, 0, 1, 'h4000)); pl(2, 'h04, fr(6'h00, 1, 1, 1));
    pl(2, 'h08, fr(6'h00, 1, 1, 1)); pl(2, 'h0C, fi(6'h01, 0, 6, 9));
    pl(2, 'h10, fr(6'h04, 6, 1, 1)); pl(2, 'h14, HALT);
    vecs[2] = mk("mul", 6, r6_exp, mul_ic, 30, 0, 0, 0, 0, 0);
    // 3: MULI signed
    pl(3, 'h00, fi(6'h01, 0, 7, -3)); pl(3, 'h04, fi(6'h05, 7, 8, 7)); pl(3, 'h08, HALT);
    vecs[3] = mk("muli", 8, r8_exp, muli_ic, 15, 0, 0, 0, 0, 0);
    // 4: R0 write discarded, unknown opcode as NOP, SUBI
    pl(4, 'h00, fi(6'h01, 0, 0, 7)); pl(4, 'h04, 32'hFC00_0000);
    pl(4, 'h08, fi(6'h03, 0, 9, -1)); pl(4, 'h0C, HALT);
    vecs[4] = mk("nop_r0", 9, 32'd1, 3, 20, 0, 0, 0, 0, 0);
    // 5: BZ taken, BEQ not taken
    pl(5, 'h00, fi(6'h0E, 0, 0, 3)); pl(5, 'h04, fi(6'h01, 0, 1, 1));
    pl(5, 'h08, fi(6'h01, 0, 1, 2)); pl(5, 'h0C, fi(6'h01, 0, 2, 5));
    pl(5, 'h10, fi(6'h0F, 2, 0, 2)); pl(5, 'h14, fi(6'h01, 2, 1, 1)); pl(5, 'h18, HALT);
    vecs[5] = mk("branch", 1, 32'd6, 5, 25, 1, 0, 0, 0, 0);
    // 6: JR unaligned target, BEQ taken
    pl(6, 'h00, fi(6'h01, 0, 5, 'h42)); pl(6, 'h04, fi(6'h10, 5, 0, 0));
    pl(6, 'h08, fi(6'h01, 0, 3, 1)); pl(6, 'h40, fi(6'h01, 0, 3, 3));
    pl(6, 'h44, fi(6'h0F, 3, 3, 2)); pl(6, 'h48, fi(6'h01, 0, 3, 99)); pl(6, 'h4C, HALT);
    vecs[6] = mk("jr", 3, 32'd3, 5, 25, 2, 0, 0, 0, 0);
    // 7: load then store
    pl(7, 'h100, 32'h1234_5678); pl(7, 'h00, fi(6'h0C, 0, 4, 'h100));
    pl(7, 'h04, fi(6'h0D, 0, 4, 'h104)); pl(7, 'h08, HALT);
    vecs[7] = mk("ldst", 4, 32'h1234_5678, 3, 15, 0, 1, 1, 'h104, 32'h1234_5678);
    // 8: store overwrites the next instruction with HALT
    pl(8, 'h100, HALT); pl(8, 'h00, fi(6'h0C, 0, 2, 'h100));
    pl(8, 'h04, fi(6'h0D, 0, 2, 'h08)); pl(8, 'h08, fi(6'h01, 0, 3, 1)); pl(8, 'h0C, HALT);
    vecs[8] = mk("selfmod", 3, 32'd0, 3, 15, 0, 1, 1, 'h08, HALT);
    // 9: backward branch
    pl(9, 'h00, fi(6'h0E, 0, 0, 2)); pl(9, 'h04, HALT);
    pl(9, 'h08, fi(6'h01, 0, 1, 4)); pl(9, 'h0C, fi(6'h0F, 0, 0, -2));
    vecs[9] = mk("backward", 1, 32'd4, 4, 20, 2, 0, 0, 0, 0);

    #1;
    chk("reset outputs", {mem_addr, mem_wdata, pc_out, instr_count, cycle_count, branch_count}, 32'd0);
    chk("reset strobes", {29'd0, mem_re, mem_we, fex}, 32'd0);

    for (int k = 0; k < 10; k++) run_vec(k);

    check_fetch("bz_target", 5, 6, 32'h0C);
    check_fetch("beq_fallthrough", 5, 16, 32'h14);
    check_fetch("jr_target", 6, 11, 32'h40);

    // Reset during the MEMORY cycle of the STW.
    load_vec(7);
    w0 = wr_cnt;
    release_rst();
    n = 0;
    while (!mem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stw_memory_cycle", n, 8);
    rst = 1'b1;
    #1;
    chk("midrst outputs", mem_addr | mem_wdata | pc_out | instr_count | cycle_count | branch_count, 32'd0);
    chk("midrst strobes", {29'd0, mem_re, mem_we, fex}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst no_store", wr_cnt - w0, 0);
    chk("midrst mem", mem[10'h41], 32'd0);
    release_rst();
    #1;
    chk("restart fetch", {mem_addr[30:0], mem_re}, {31'd0, 1'b1});
    n = 0;
    while (!fex && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("restart cycle_count", cycle_count, 32'd15);
    chk("restart stores", wr_cnt - w0, 1);
    chk("strobe overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
